// File: rtl/alu_seq.sv
// Sequential ALU with ready/valid handshake: single-cycle ops finish in one cycle, MUL/MULHU
// use a WIDTH-step shift-add multiplier. Define ALU_SEQ_MUL_EN to build the multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_code,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             negative_flag,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             illegal_flag
);

  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_NOP   = 4'b1111;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_MULHU = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W1-1:0]    add_sum, sub_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_res;
  logic             op_carry, op_ovf, op_illegal, op_mul;

  logic [WIDTH-1:0] mul_res;
  logic             mul_last;

  logic             ready_d, valid_d;
  logic [WIDTH-1:0] result_d;
  logic             neg_d, zero_d, carry_d, ovf_d, ill_d;

  // Single-cycle datapath evaluated on the live inputs; registered on the accepting edge.
  always_comb begin
    op_res     = '0;
    op_carry   = 1'b0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    op_mul     = 1'b0;
    add_sum    = {1'b0, alu_in1} + {1'b0, alu_in2};
    sub_sum    = {1'b0, alu_in1} + {1'b0, ~alu_in2} + W1'(1);
    shamt      = alu_in2[SHW-1:0];
    case (alu_code)
      OP_ADD: begin
        op_res   = add_sum[WIDTH-1:0];
        op_carry = add_sum[WIDTH];
        op_ovf   = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      OP_SUB: begin
        op_res   = sub_sum[WIDTH-1:0];
        op_carry = sub_sum[WIDTH];
        op_ovf   = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                   (sub_sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      OP_SLL:  op_res = alu_in1 << shamt;
      OP_SRL:  op_res = alu_in1 >> shamt;
      OP_SRA:  op_res = $unsigned($signed(alu_in1) >>> shamt);
      OP_SLT:  op_res = WIDTH'($signed(alu_in1) < $signed(alu_in2));
      OP_SLTU: op_res = WIDTH'(alu_in1 < alu_in2);
      OP_XOR:  op_res = alu_in1 ^ alu_in2;
      OP_OR:   op_res = alu_in1 | alu_in2;
      OP_AND:  op_res = alu_in1 & alu_in2;
      OP_NOP:  op_res = '0;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL, OP_MULHU: op_mul = 1'b1;
`else
      OP_MUL, OP_MULHU: op_illegal = 1'b1;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_next;
  logic [W1-1:0]      step_sum;
  logic [SHW-1:0]     cnt;
  logic               mul_hi;

  // One shift-add step: conditionally add multiplicand into the upper half, then shift right.
  always_comb begin
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : W1'(0));
    prod_next = {step_sum, prod[WIDTH-1:1]};
    mul_last  = (cnt == SHW'(WIDTH - 1));
    mul_res   = mul_hi ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      mul_hi <= 1'b0;
    end else if (state == IDLE && in_valid && in_ready && op_mul) begin
      mcand  <= alu_in1;
      prod   <= {{WIDTH{1'b0}}, alu_in2};
      cnt    <= '0;
      mul_hi <= alu_code[3];
    end else if (state == BUSY) begin
      prod <= prod_next;
      cnt  <= cnt + SHW'(1);
    end
  end
`else
  assign mul_res  = '0;
  assign mul_last = 1'b0;
`endif

  // Next-state and next-output logic; every output is held unless a transition updates it.
  always_comb begin
    state_next = state;
    ready_d    = in_ready;
    valid_d    = out_valid;
    result_d   = alu_result;
    carry_d    = carry_flag;
    ovf_d      = overflow_flag;
    ill_d      = illegal_flag;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          ready_d = 1'b0;
          if (op_mul) begin
            state_next = BUSY;
          end else begin
            state_next = DONE;
            valid_d    = 1'b1;
            result_d   = op_res;
            carry_d    = op_carry;
            ovf_d      = op_ovf;
            ill_d      = op_illegal;
          end
        end
      end
      BUSY: begin
        if (mul_last) begin
          state_next = DONE;
          valid_d    = 1'b1;
          result_d   = mul_res;
          carry_d    = 1'b0;
          ovf_d      = 1'b0;
          ill_d      = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          ready_d    = 1'b1;
          valid_d    = 1'b0;
          result_d   = '0;
          carry_d    = 1'b0;
          ovf_d      = 1'b0;
          ill_d      = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ready_d    = 1'b1;
        valid_d    = 1'b0;
        result_d   = '0;
        carry_d    = 1'b0;
        ovf_d      = 1'b0;
        ill_d      = 1'b0;
      end
    endcase
    neg_d  = valid_d && result_d[WIDTH-1];
    zero_d = valid_d && (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      alu_result    <= '0;
      negative_flag <= 1'b0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_flag  <= 1'b0;
    end else begin
      state         <= state_next;
      in_ready      <= ready_d;
      out_valid     <= valid_d;
      alu_result    <= result_d;
      negative_flag <= neg_d;
      zero_flag     <= zero_d;
      carry_flag    <= carry_d;
      overflow_flag <= ovf_d;
      illegal_flag  <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed corner cases, reset aborts and
// randomized operations against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_code;
  logic [W-1:0]  alu_in1, alu_in2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_result;
  logic          negative_flag, zero_flag, carry_flag, overflow_flag, illegal_flag;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] last_res;
  logic [4:0]   last_fl;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;   // {negative, zero, carry, overflow, illegal}
    logic [7:0]  lat;
  } exp_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
  } dir_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_code      (alu_code),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .negative_flag (negative_flag),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .illegal_flag  (illegal_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {negative_flag, zero_flag, carry_flag, overflow_flag, illegal_flag};
  endfunction

  // Reference model from plain 64-bit arithmetic.
  function automatic exp_t ref_model(input logic [3:0] code, input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t            e;
    longint unsigned ua, ub, wide;
    longint          sa, sb, ws;
    int unsigned     sh;
    logic            c, v, ill;
    ua = 64'(a);
    ub = 64'(b);
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    sh = 32'(b[4:0]);
    c = 1'b0; v = 1'b0; ill = 1'b0;
    e = '0;
    e.lat = 8'd1;
    case (code)
      4'h0: begin
        wide = ua + ub; ws = sa + sb;
        e.res = wide[31:0]; c = wide[32];
        v = (ws > 64'sd2147483647) || (ws < -64'sd2147483648);
      end
      4'h8: begin
        ws = sa - sb;
        e.res = 32'(ua - ub); c = (ua >= ub);
        v = (ws > 64'sd2147483647) || (ws < -64'sd2147483648);
      end
      4'h1: e.res = a << sh;
      4'h5: e.res = a >> sh;
      4'hD: e.res = 32'(sa >>> sh);
      4'h2: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'hA: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'h4: e.res = a ^ b;
      4'h6: e.res = a | b;
      4'h7: e.res = a & b;
      4'hF: e.res = 32'd0;
`ifdef ALU_SEQ_MUL_EN
      4'h3, 4'hB: begin
        wide = ua * ub;
        e.res = code[3] ? wide[63:32] : wide[31:0];
        e.lat = 8'(W + 1);
      end
`endif
      default: ill = 1'b1;
    endcase
    e.fl = {e.res[31], (e.res == 32'd0), c, v, ill};
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, wait for its result, hold it for 'hold' cycles, then consume it.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    exp_t e;
    int   cyc;
    logic bad;
    e = ref_model(code, a, b);
    @(negedge clk);
    check("accept_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1; alu_code = code; alu_in1 = a; alu_in2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_code = 4'($urandom); alu_in1 = $urandom; alu_in2 = $urandom;
    cyc = 1;
    bad = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready || alu_result != '0 || flags() != 5'd0) bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(e.lat));
    check("busy_quiet", 64'(bad), 64'(0));
    check("result", 64'(alu_result), 64'(e.res));
    check("flags", 64'(flags()), 64'(e.fl));
    last_res = alu_result;
    last_fl  = flags();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; alu_code = 4'($urandom); alu_in1 = $urandom; alu_in2 = $urandom;
      @(posedge clk); #1;
      check("hold_state", 64'({out_valid, in_ready}), 64'(2'b10));
      check("hold_result", 64'(alu_result), 64'(last_res));
      check("hold_flags", 64'(flags()), 64'(last_fl));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("released", 64'({out_valid, in_ready, alu_result, flags()}),
          64'({1'b0, 1'b1, 32'd0, 5'd0}));
  endtask

  task automatic idle_no_valid(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'(0));
  endtask

  dir_t dirs[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_code = 4'h0; alu_in1 = '0; alu_in2 = '0;
    last_res = '0; last_fl = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("reset_state", 64'({in_ready, out_valid, alu_result, flags()}),
             64'({1'b1, 1'b0, 32'd0, 5'd0}));

    dirs.push_back('{code: 4'h8, a: 32'd5,          b: 32'd7,          res: 32'hFFFF_FFFE, fl: 5'b10000});
    dirs.push_back('{code: 4'h0, a: 32'h7FFF_FFFF, b: 32'd1,          res: 32'h8000_0000, fl: 5'b10010});
    dirs.push_back('{code: 4'h0, a: 32'hFFFF_FFFF, b: 32'd1,          res: 32'h0000_0000, fl: 5'b01100});
    dirs.push_back('{code: 4'hD, a: 32'h8000_0000, b: 32'h21,         res: 32'hC000_0000, fl: 5'b10000});
    dirs.push_back('{code: 4'hA, a: 32'd1,          b: 32'hFFFF_FFFF, res: 32'd1,          fl: 5'b00000});
    dirs.push_back('{code: 4'h2, a: 32'd1,          b: 32'hFFFF_FFFF, res: 32'd0,          fl: 5'b01000});
    dirs.push_back('{code: 4'hE, a: 32'h1234_5678, b: 32'h9ABC_DEF0, res: 32'd0,          fl: 5'b01001});
    dirs.push_back('{code: 4'hF, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'd0,          fl: 5'b01000});
`ifdef ALU_SEQ_MUL_EN
    dirs.push_back('{code: 4'hB, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFE, fl: 5'b10000});
    dirs.push_back('{code: 4'h3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'h0000_0001, fl: 5'b00000});
`else
    dirs.push_back('{code: 4'h3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'd0,          fl: 5'b01001});
    dirs.push_back('{code: 4'hB, a: 32'd3,          b: 32'd5,          res: 32'd0,          fl: 5'b01001});
`endif

    foreach (dirs[i]) begin
      run_op(dirs[i].code, dirs[i].a, dirs[i].b, (i == 0) ? 5 : 0);
      check("dir_result", 64'(last_res), 64'(dirs[i].res));
      check("dir_flags", 64'(last_fl), 64'(dirs[i].fl));
    end

    // Reset while the result is being presented: output clears at once, nothing re-emerges.
    @(negedge clk);
    in_valid = 1'b1; alu_code = 4'h0; alu_in1 = 32'd1; alu_in2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("async_reset_done", 64'({out_valid, alu_result, flags()}), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    run_op(4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1);

`ifdef ALU_SEQ_MUL_EN
    // Reset in the third BUSY cycle of a multiply aborts it.
    @(negedge clk);
    in_valid = 1'b1; alu_code = 4'h3; alu_in1 = 32'd12345; alu_in2 = 32'd678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_busy", 64'({out_valid, alu_result, flags()}), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_after_reset", 64'(in_ready), 64'(1));
    idle_no_valid(W + 8, "aborted_mul_silent");
    run_op(4'h3, 32'd12345, 32'd678, 0);
`else
    idle_no_valid(8, "idle_silent");
`endif

    for (int n = 0; n < 200; n++) begin
      run_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
             int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have parameter SHW, default $clog2(WIDTH), giving the number of shift-amount bits used; it is not overridden.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, request present.
REQ-006 Port in_ready, output, 1, unit able to accept a request.
REQ-007 Port alu_code, input, 4, operation code.
REQ-008 Port alu_in1 and alu_in2, input, WIDTH each, operands, interpreted as two's complement signed unless the operation states otherwise.
REQ-009 Port out_valid, output, 1, result and flags valid.
REQ-010 Port out_ready, input, 1, consumer accepts the result.
REQ-011 Port alu_result, output, WIDTH, result.
REQ-012 Ports negative_flag, zero_flag, carry_flag, overflow_flag, illegal_flag, output, 1 each, status for the presented result.

Function
REQ-013 Codes SHALL be ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 1010, XOR 0100, OR 0110, AND 0111, SRL 0101, SRA 1101, NOP 1111, MUL 0011, MULHU 1011; codes 1001, 1100, 1110 are reserved.
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; in_ready is 1 only in IDLE.
REQ-015 A request SHALL be accepted on a cycle with in_valid=1 and in_ready=1; operands and code are captured and later input changes have no effect.
REQ-016 Non-MUL codes SHALL go IDLE->DONE, so out_valid rises the cycle after acceptance (latency 1).
REQ-017 MUL/MULHU SHALL go IDLE->BUSY, run one shift-add step per cycle for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-018 MUL SHALL return the low WIDTH bits and MULHU the high WIDTH bits of the unsigned 2*WIDTH-bit product.
REQ-019 DONE SHALL hold alu_result and all flags stable while out_valid=1 and out_ready=0, and go to IDLE on the cycle out_ready=1.
REQ-020 Shifts SHALL use only alu_in2[SHW-1:0] as the amount; SRA replicates the sign bit, SRL and SLL fill zeros.
REQ-021 SLT SHALL compare signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-022 carry_flag SHALL be the carry-out of alu_in1 + ~alu_in2 + 1 for SUB (1 when alu_in1 >= alu_in2 unsigned), the carry-out of the WIDTH+1-bit sum for ADD, and 0 otherwise.
REQ-023 overflow_flag SHALL be the signed overflow of ADD or SUB and 0 otherwise.
REQ-024 negative_flag SHALL equal alu_result[WIDTH-1] and zero_flag SHALL be 1 when alu_result is all zeros, for every code.
REQ-025 NOP and reserved codes SHALL produce result 0 with latency 1; illegal_flag is 1 only for reserved codes.
REQ-026 While out_valid=0, alu_result and all flags SHALL read 0.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, alu_result=0 and all flags 0, including mid-MUL or in DONE; the aborted operation produces no result.
REQ-028 The first request SHALL be acceptable on the first rising clk edge after rst_n is released.

Configuration
REQ-029 With macro ALU_SEQ_MUL_EN defined, MUL and MULHU SHALL behave per REQ-017/018; without it, codes 0011 and 1011 SHALL be treated as reserved (latency 1, result 0, illegal_flag=1) and no multiplier datapath is built.

Verification
REQ-030 WIDTH=32, SUB 5-7 -> one cycle later out_valid=1, result 0xFFFFFFFE, negative=1, zero=0, carry=0, overflow=0.
REQ-031 WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, negative=1, carry=0; ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1.
REQ-032 WIDTH=32, SRA 0x80000000 by alu_in2=0x21 -> amount 1, result 0xC0000000; SLTU 1 vs 0xFFFFFFFF -> 1, SLT same operands -> 0.
REQ-033 ALU_SEQ_MUL_EN, WIDTH=8, MULHU 0xFF*0xFF -> in_ready=0 for 8 BUSY cycles, out_valid on cycle 9, result 0xFE; MUL same -> 0x01.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n low at BUSY cycle 3 of MUL -> out_valid stays 0, no result emitted, next request processed normally; code 1110 -> result 0, illegal=1, zero=1.
